// File: rtl/haze_pkg.sv
// Shared defaults and types for the haze-removal pixel pipeline.
package haze_pkg;
  localparam int DEF_DW     = 8;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;
  localparam int WIN_CENTRE = 5;

  typedef logic [DEF_DW-1:0] pixel_t;
endpackage

// File: rtl/line_buffer.sv
// One image row of storage: asynchronous read and synchronous write at the
// same address, so the read always returns the value from before this write.
module line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/window3x3_gen.sv
// Raster stream to 3x3 window generator: two line buffers feed a 3-column
// shift register; interior windows are strobed out two cycles after acceptance.
module window3x3_gen
  import haze_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DW    = DEF_DW
)(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic [DW-1:0]            pix_in,
  output logic                     win_valid,
  output logic [DW-1:0]            pixel_1,
  output logic [DW-1:0]            pixel_2,
  output logic [DW-1:0]            pixel_3,
  output logic [DW-1:0]            pixel_4,
  output logic [DW-1:0]            pixel_5,
  output logic [DW-1:0]            pixel_6,
  output logic [DW-1:0]            pixel_7,
  output logic [DW-1:0]            pixel_8,
  output logic [DW-1:0]            pixel_9,
  output logic [$clog2(IMG_W)-1:0] win_cx,
  output logic [$clog2(IMG_H)-1:0] win_cy
);
  localparam int CXW = $clog2(IMG_W);
  localparam int CYW = $clog2(IMG_H);
  typedef logic [CXW-1:0] cx_t;
  typedef logic [CYW-1:0] cy_t;
  localparam cx_t X_LAST = cx_t'(IMG_W - 1);
  localparam cx_t X_ONE  = cx_t'(1);
  localparam cx_t X_TWO  = cx_t'(2);
  localparam cy_t Y_LAST = cy_t'(IMG_H - 1);
  localparam cy_t Y_ONE  = cy_t'(1);
  localparam cy_t Y_TWO  = cy_t'(2);

  logic                     acc, kill, emit_d, acc_q;
  cx_t                      col_q, col_d, x, cx1_q, cx2_q;
  cy_t                      row_q, row_d, y, cy1_q, cy2_q;
  logic [DW-1:0]            rd0, rd1, rd0_q, rd1_q, pix_q;
  logic [2:0]               vld_pipe;
  // win_q[column][row]: column 0 is leftmost, row 2 is the oldest line
  logic [2:0][2:0][DW-1:0]  win_q;
  logic [8:0][DW-1:0]       out_q;

  always_comb begin
    acc    = pix_valid;
    kill   = pix_valid & pix_sof;
    x      = kill ? '0 : col_q;
    y      = kill ? '0 : row_q;
    col_d  = col_q;
    row_d  = row_q;
    if (acc) begin
      if (x == X_LAST) begin
        col_d = '0;
        row_d = (y == Y_LAST) ? '0 : y + Y_ONE;
      end else begin
        col_d = x + X_ONE;
        row_d = y;
      end
    end
    emit_d = acc && (x >= X_TWO) && (y >= Y_TWO);
  end

  line_buffer #(.DEPTH(IMG_W), .DW(DW)) lb1 (
    .clk_i(clock), .we_i(acc), .addr_i(x), .wdata_i(pix_in), .rdata_o(rd1)
  );
  line_buffer #(.DEPTH(IMG_W), .DW(DW)) lb0 (
    .clk_i(clock), .we_i(acc), .addr_i(x), .wdata_i(rd1), .rdata_o(rd0)
  );

  // A start-of-frame kills any old-frame windows still in the pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q    <= '0;
      row_q    <= '0;
      vld_pipe <= '0;
      acc_q    <= 1'b0;
      pix_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      cx1_q    <= '0;
      cy1_q    <= '0;
      cx2_q    <= '0;
      cy2_q    <= '0;
      win_q    <= '0;
      out_q    <= '0;
      win_cx   <= '0;
      win_cy   <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      vld_pipe <= {vld_pipe[1] & ~kill, vld_pipe[0] & ~kill, emit_d};
      acc_q    <= acc;
      if (acc) begin
        pix_q <= pix_in;
        rd0_q <= rd0;
        rd1_q <= rd1;
        cx1_q <= x - X_ONE;
        cy1_q <= y - Y_ONE;
      end
      if (acc_q) begin
        win_q <= {{rd0_q, rd1_q, pix_q}, win_q[2], win_q[1]};
        cx2_q <= cx1_q;
        cy2_q <= cy1_q;
      end
      if (vld_pipe[1] & ~kill) begin
        out_q  <= {win_q[2][0], win_q[1][0], win_q[0][0],
                   win_q[2][1], win_q[1][1], win_q[0][1],
                   win_q[2][2], win_q[1][2], win_q[0][2]};
        win_cx <= cx2_q;
        win_cy <= cy2_q;
      end
    end
  end

  assign win_valid = vld_pipe[2];
  assign pixel_1   = out_q[0];
  assign pixel_2   = out_q[1];
  assign pixel_3   = out_q[2];
  assign pixel_4   = out_q[3];
  assign pixel_5   = out_q[4];
  assign pixel_6   = out_q[5];
  assign pixel_7   = out_q[6];
  assign pixel_8   = out_q[7];
  assign pixel_9   = out_q[8];
endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen on a 4x4 image: hand tables plus an
// image-array reference for window contents, centres and strobe timing.
module tb_window3x3_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic       clock = 1'b0, reset_n = 1'b1, pix_valid = 1'b0, pix_sof = 1'b0;
  logic [7:0] pix_in = '0;
  logic       win_valid;
  logic [7:0] pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8, pixel_9;
  logic [1:0] win_cx, win_cy;

  typedef struct {
    logic [71:0] win;
    int          cx;
    int          cy;
    int          cyc;
  } rec_t;

  rec_t       got[$];
  rec_t       expq[$];
  rec_t       tab[4];
  int         cyc = 0, n_chk = 0, n_fail = 0, mcol = 0, mrow = 0;
  logic [7:0] img[H][W];

  window3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_in(pix_in), .win_valid(win_valid),
    .pixel_1(pixel_1), .pixel_2(pixel_2), .pixel_3(pixel_3),
    .pixel_4(pixel_4), .pixel_5(pixel_5), .pixel_6(pixel_6),
    .pixel_7(pixel_7), .pixel_8(pixel_8), .pixel_9(pixel_9),
    .win_cx(win_cx), .win_cy(win_cy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (win_valid)
      got.push_back('{win: {pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
                            pixel_6, pixel_7, pixel_8, pixel_9},
                      cx: int'(win_cx), cy: int'(win_cy), cyc: cyc});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: remember the image, emit every interior window with its due cycle.
  task automatic model_accept(input logic s, input logic [7:0] p);
    rec_t r;
    if (s) begin
      mcol = 0;
      mrow = 0;
      for (int i = expq.size() - 1; i >= 0; i--)
        if (expq[i].cyc >= cyc) expq.delete(i);
    end
    img[mrow][mcol] = p;
    if (mcol >= 2 && mrow >= 2) begin
      r.win = {img[mrow-2][mcol-2], img[mrow-2][mcol-1], img[mrow-2][mcol],
               img[mrow-1][mcol-2], img[mrow-1][mcol-1], img[mrow-1][mcol],
               img[mrow][mcol-2],   img[mrow][mcol-1],   img[mrow][mcol]};
      r.cx  = mcol - 1;
      r.cy  = mrow - 1;
      r.cyc = cyc + 2;
      expq.push_back(r);
    end
    if (mcol == W - 1) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] p);
    pix_valid = v;
    pix_sof   = s;
    pix_in    = p;
    @(posedge clock);
    #1;
    if (v) model_accept(s, p);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic frame(input int base, input bit sof, input bit gap);
    for (int i = 0; i < W * H; i++) begin
      drive(1'b1, sof && i == 0, 8'(base + i));
      if (gap) drive(1'b0, 1'b0, 8'hEE);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic compare_all(input string nm);
    check($sformatf("%s count", nm), 72'(got.size()), 72'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      check($sformatf("%s win[%0d]", nm, i), got[i].win, expq[i].win);
      check($sformatf("%s cx[%0d]", nm, i), 72'(got[i].cx), 72'(expq[i].cx));
      check($sformatf("%s cy[%0d]", nm, i), 72'(got[i].cy), 72'(expq[i].cy));
      check($sformatf("%s cyc[%0d]", nm, i), 72'(got[i].cyc), 72'(expq[i].cyc));
    end
  endtask

  task automatic compare_tab(input string nm, input int off);
    for (int i = 0; i < 4; i++) begin
      if (off + i < got.size()) begin
        check($sformatf("%s tab win[%0d]", nm, i), got[off+i].win, tab[i].win);
        check($sformatf("%s tab cx[%0d]", nm, i), 72'(got[off+i].cx), 72'(tab[i].cx));
        check($sformatf("%s tab cy[%0d]", nm, i), 72'(got[off+i].cy), 72'(tab[i].cy));
      end else begin
        check($sformatf("%s tab missing[%0d]", nm, i), 72'(got.size()), 72'(off + i + 1));
      end
    end
  endtask

  task automatic clear();
    got.delete();
    expq.delete();
  endtask

  task automatic check_zero(input string nm);
    check({nm, " win_valid"}, 72'(win_valid), 72'(0));
    check({nm, " pixels"}, {pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
                            pixel_6, pixel_7, pixel_8, pixel_9}, 72'(0));
    check({nm, " cx"}, 72'(win_cx), 72'(0));
    check({nm, " cy"}, 72'(win_cy), 72'(0));
  endtask

  initial begin
    tab[0] = '{win: 72'h00_01_02_04_05_06_08_09_0A, cx: 1, cy: 1, cyc: 0};
    tab[1] = '{win: 72'h01_02_03_05_06_07_09_0A_0B, cx: 2, cy: 1, cyc: 0};
    tab[2] = '{win: 72'h04_05_06_08_09_0A_0C_0D_0E, cx: 1, cy: 2, cyc: 0};
    tab[3] = '{win: 72'h05_06_07_09_0A_0B_0D_0E_0F, cx: 2, cy: 2, cyc: 0};

    #2 reset_n = 1'b0;
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    clear();

    // Basic continuous frame
    frame(0, 1'b1, 1'b0);
    drain();
    compare_all("basic");
    compare_tab("basic", 0);
    clear();

    // Same frame, valid low every other cycle
    frame(0, 1'b1, 1'b1);
    drain();
    compare_all("gapped");
    compare_tab("gapped", 0);
    clear();

    // Two frames back to back, second without sof
    frame(0, 1'b1, 1'b0);
    frame(100, 1'b0, 1'b0);
    drain();
    compare_all("b2b");
    if (got.size() > 4)
      check("b2b 5th window", got[4].win, 72'h64_65_66_68_69_6A_6C_6D_6E);
    else
      check("b2b 5th missing", 72'(got.size()), 72'(5));
    clear();

    // Restart at pixel index 9 of a frame
    for (int i = 0; i < 9; i++) drive(1'b1, i == 0, 8'(i));
    frame(50, 1'b1, 1'b0);
    drain();
    compare_all("restart");
    if (got.size() > 0)
      check("restart 1st window", got[0].win, 72'h32_33_34_36_37_38_3A_3B_3C);
    else
      check("restart 1st missing", 72'(got.size()), 72'(1));
    clear();

    // Restart right behind two in-flight old-frame windows
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, 8'(i));
    frame(0, 1'b1, 1'b0);
    drain();
    compare_all("kill");
    compare_tab("kill", 0);
    clear();

    // Reset right after pixel 10 is accepted
    for (int i = 0; i < 11; i++) drive(1'b1, i == 0, 8'(i));
    reset_n = 1'b0;
    expq.delete();
    mcol = 0;
    mrow = 0;
    repeat (3) @(negedge clock);
    check_zero("midreset");
    check("midreset strobes", 72'(got.size()), 72'(0));
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check_zero("post-reset");
    frame(0, 1'b0, 1'b0);
    drain();
    compare_all("after reset");
    compare_tab("after reset", 0);
    clear();

    // Random frames with random gaps across row and frame wraps
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W * H; i++) begin
        drive(1'b1, f == 0 && i == 0, 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 8'h55);
      end
    end
    drain();
    compare_all("random");
    check("random count 12", 72'(got.size()), 72'(12));
    clear();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

Raster-to-window generator for the haze-removal pipeline: accepts one 8-bit pixel per valid cycle in raster order and emits every fully interior 3×3 neighbourhood as nine parallel pixels plus a one-cycle valid strobe. It is the producer side of the nine-pixel window interface consumed by the dark-channel minimum filter. Its outputs connect directly to that filter's `Enable` and pixel inputs. Two internal line buffers hold the previous two image rows.

## Interface
- `IMG_W`, 640, pixels per line (≥3)
- `IMG_H`, 480, lines per frame (≥3)
- `DW`, 8, pixel width in bits
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `pix_valid`  in  1  `pix_in` is accepted this cycle
- `pix_sof`  in  1  qualifies `pix_valid`; the accepted pixel is (x=0, y=0)
- `pix_in`  in  DW  input pixel
- `win_valid`  out  1  one-cycle strobe; drives the filter's `Enable`
- `pixel_1`…`pixel_9`  out  DW each  window in row-major order; `pixel_1` is top-left, `pixel_5` is the centre, `pixel_9` is bottom-right
- `win_cx`  out  clog2(IMG_W)  centre column of the current window
- `win_cy`  out  clog2(IMG_H)  centre row of the current window

## Operation
- Counters `col` and `row` give the position of the next accepted pixel.
  - `col` increments on every accepted pixel and wraps at IMG_W−1 to 0, incrementing `row`.
  - `row` wraps at IMG_H−1 to 0, so back-to-back frames need no `pix_sof`.
- An accepted pixel with `pix_sof=1` is position (0,0), regardless of counter state.
  - A mid-frame `pix_sof` abandons the old frame. No window of the old frame is emitted after it.
- Line buffer update for an accepted pixel at column x:
  - read `lb1[x]` (row y−1) and `lb0[x]` (row y−2);
  - then write `lb0[x] ← old lb1[x]` and `lb1[x] ← pix_in` (read-before-write).
- The window register shifts left by one column per accepted pixel. The new right column is {lb0[x], lb1[x], pix_in}, top to bottom.
- A window is emitted for an accepted pixel at (x,y) only when x≥2 and y≥2.
  - Centre is (x−1, y−1); `pixel_9` is the accepted pixel.
  - Each frame yields exactly (IMG_W−2)·(IMG_H−2) windows; border centres are never emitted.
- The window shift register also shifts across line starts. Windows with x<2 are suppressed, so stale columns are never emitted.
- There is no backpressure; the consumer must accept every strobe.
- Line buffer contents are not reset. Rows 0–1 of each frame refill them before any emission.

## Timing
- `win_valid` asserts exactly 2 cycles after the rising edge that accepts the qualifying pixel. This latency is fixed and independent of `pix_valid` gaps.
- All outputs are registered.
  - `pixel_*`, `win_cx` and `win_cy` hold their last values until the next window.
  - `win_valid` is high for one cycle per window.
- Reset (asynchronous assert, synchronous release):
  - `win_valid`, every `pixel_*`, `win_cx`, `win_cy`, `col` and `row` become 0;
  - in-flight pipeline valids are cleared, so no window is emitted from pre-reset data.
- Gaps: `pix_valid=0` cycles freeze the counters and window register. In-flight pipeline stages still drain.
- `pix_sof` while `pix_valid=0` is ignored.
- Full rate: one window per cycle is sustained with `pix_valid` held high.

## Structure
- Shared package `haze_pkg` holds `DW`, `IMG_W` and `IMG_H` defaults, the `pixel_t` typedef (logic [DW−1:0]), and the window-index constant `WIN_CENTRE=5`.
- One sub-module, `line_buffer`: depth IMG_W, width DW, one read and one write port at the same address, read-before-write. It is instantiated twice (`lb0`, `lb1`).
- The top level contains the counters, the 3×3 shift register, the emit qualifier and the 2-stage valid pipeline.

## Test plan
- **Basic 4×4 frame.** IMG_W=IMG_H=4, pixels 0..15 with `pix_sof` on pixel 0, continuous valid.
  - Exactly 4 strobes.
  - The first arrives 2 cycles after pixel 10, with window 0,1,2,4,5,6,8,9,10 and centre (1,1).
  - The last has window 5,6,7,9,10,11,13,14,15 and centre (2,2).
- **Gapped input.** Same frame with `pix_valid` low on every second cycle → identical window values and count, each strobe 2 cycles after its qualifying pixel.
- **Back-to-back frames.** Two 4×4 frames without a second `pix_sof`, the second frame using values 100..115 → 8 windows; the 5th window is 100,101,102,104,105,106,108,109,110.
- **Mid-frame restart.** `pix_sof` asserted at pixel index 9 of the first frame, followed by a full frame → 4 windows total, all from the new frame.
- **Reset mid-frame.** `reset_n` pulsed low after pixel 10 is accepted → `win_valid` never asserts for pixel 10. All outputs read 0 until the next full frame, which yields 4 correct windows.
- **Row wrap.** 640×480 random frame checked against a reference model → 638·478 windows. The first window of each line has `win_cx`=1, and `win_cy` increments per line.
